// File: rtl/corepwm_pkg.sv
// Shared encodings and packing helpers for the PWM timebase / register-update block.
package corepwm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tb_state_t;

    typedef enum logic {
        EDGE_POS = 1'b0,
        EDGE_NEG = 1'b1
    } wr_edge_t;

    // Channel vectors are numbered from bit 1; channel ch starts at this bit.
    localparam int unsigned CH_BASE_BIT = 1;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return (ch - 1) * width + CH_BASE_BIT;
    endfunction

endpackage

// File: rtl/corepwm_shadow_bank.sv
// One channel's shadow/active register pair for the posedge and negedge values.
module corepwm_shadow_bank
    import corepwm_pkg::*;
#(
    parameter int unsigned APB_DWIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  wr_edge_t              wr_edge,
    input  logic [APB_DWIDTH-1:0] wr_data,
    input  logic                  commit,
    output logic [APB_DWIDTH-1:0] pos_active,
    output logic [APB_DWIDTH-1:0] neg_active
);

    logic [APB_DWIDTH-1:0] pos_shadow;
    logic [APB_DWIDTH-1:0] neg_shadow;

    // A write landing on the commit edge stays in the shadow; active takes the old shadow.
    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            pos_shadow <= '0;
            neg_shadow <= '0;
            pos_active <= '0;
            neg_active <= '0;
        end else begin
            if (wr_en && (wr_edge == EDGE_POS)) pos_shadow <= wr_data;
            if (wr_en && (wr_edge == EDGE_NEG)) neg_shadow <= wr_data;
            if (commit) begin
                pos_active <= pos_shadow;
                neg_active <= neg_shadow;
            end
        end
    end

endmodule

// File: rtl/corepwm_timebase_ctrl.sv
// PWM timebase (prescaler + period counter) with period-boundary commit of shadowed edge registers.
module corepwm_timebase_ctrl
    import corepwm_pkg::*;
#(
    parameter  int unsigned PWM_NUM    = 8,
    parameter  int unsigned APB_DWIDTH = 8,
    localparam int unsigned SEL_W      = $clog2(PWM_NUM + 1)
) (
    input  logic                          PCLK,
    input  logic                          aresetn,
    input  logic                          run,
    input  logic [APB_DWIDTH-1:0]         prescale_reg,
    input  logic [APB_DWIDTH-1:0]         period_reg,
    input  logic                          cfg_wr_en,
    input  logic [SEL_W-1:0]              cfg_wr_sel,
    input  logic                          cfg_wr_edge,
    input  logic [APB_DWIDTH-1:0]         cfg_wr_data,
    input  logic                          update_req,
    output logic                          update_pending,
    output logic                          update_ack,
    output logic [APB_DWIDTH-1:0]         period_cnt,
    output logic                          sync_pulse,
    output logic [PWM_NUM*APB_DWIDTH:1]   pwm_posedge_reg,
    output logic [PWM_NUM*APB_DWIDTH:1]   pwm_negedge_reg
);

    localparam logic [APB_DWIDTH-1:0] CNT_ONE = 1;

    tb_state_t             state;
    logic [APB_DWIDTH-1:0] prescale_cnt;
    logic                  wrap_edge;
    logic                  commit;

    // The period counter advances on the edge where the registered tick is high.
    assign wrap_edge = sync_pulse && (period_cnt >= period_reg);
    assign commit    = update_pending && ((state == ST_IDLE) || wrap_edge);

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            prescale_cnt   <= '0;
            period_cnt     <= '0;
            sync_pulse     <= 1'b0;
            update_pending <= 1'b0;
            update_ack     <= 1'b0;
        end else begin
            state          <= run ? ST_RUN : ST_IDLE;
            update_ack     <= commit;
            // A request on the commit edge re-arms for the next boundary.
            update_pending <= commit ? update_req : (update_pending | update_req);
            if (state == ST_IDLE) begin
                prescale_cnt <= '0;
                period_cnt   <= '0;
                sync_pulse   <= 1'b0;
            end else begin
                if (prescale_cnt >= prescale_reg) begin
                    prescale_cnt <= '0;
                    sync_pulse   <= 1'b1;
                end else begin
                    prescale_cnt <= prescale_cnt + CNT_ONE;
                    sync_pulse   <= 1'b0;
                end
                if (sync_pulse) begin
                    period_cnt <= wrap_edge ? '0 : period_cnt + CNT_ONE;
                end
            end
        end
    end

    for (genvar z = 1; z <= PWM_NUM; z++) begin : g_ch
        localparam int unsigned LSB = ch_lsb(z, APB_DWIDTH);
        logic sel_hit;
        assign sel_hit = cfg_wr_en && (cfg_wr_sel == SEL_W'(z));

        corepwm_shadow_bank #(
            .APB_DWIDTH (APB_DWIDTH)
        ) u_bank (
            .PCLK       (PCLK),
            .aresetn    (aresetn),
            .wr_en      (sel_hit),
            .wr_edge    (wr_edge_t'(cfg_wr_edge)),
            .wr_data    (cfg_wr_data),
            .commit     (commit),
            .pos_active (pwm_posedge_reg[LSB +: APB_DWIDTH]),
            .neg_active (pwm_negedge_reg[LSB +: APB_DWIDTH])
        );
    end

endmodule

// File: tb/tb_corepwm_timebase_ctrl.sv
// Randomized and directed checks of corepwm_timebase_ctrl against a behavioural model.
module tb_corepwm_timebase_ctrl;

    localparam int N = 8;
    localparam int W = 8;

    logic         PCLK = 1'b0;
    logic         aresetn;
    logic         run;
    logic [W-1:0] prescale_reg;
    logic [W-1:0] period_reg;
    logic         cfg_wr_en;
    logic [3:0]   cfg_wr_sel;
    logic         cfg_wr_edge;
    logic [W-1:0] cfg_wr_data;
    logic         update_req;
    logic         update_pending;
    logic         update_ack;
    logic [W-1:0] period_cnt;
    logic         sync_pulse;
    logic [N*W:1] pwm_posedge_reg;
    logic [N*W:1] pwm_negedge_reg;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic         m_run_st, m_sync, m_pend, m_ack;
    logic [W-1:0] m_pcnt, m_per;
    logic [W-1:0] m_sh_pos [1:N];
    logic [W-1:0] m_sh_neg [1:N];
    logic [W-1:0] m_ac_pos [1:N];
    logic [W-1:0] m_ac_neg [1:N];

    corepwm_timebase_ctrl #(.PWM_NUM(N), .APB_DWIDTH(W)) dut (
        .PCLK            (PCLK),
        .aresetn         (aresetn),
        .run             (run),
        .prescale_reg    (prescale_reg),
        .period_reg      (period_reg),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_sel      (cfg_wr_sel),
        .cfg_wr_edge     (cfg_wr_edge),
        .cfg_wr_data     (cfg_wr_data),
        .update_req      (update_req),
        .update_pending  (update_pending),
        .update_ack      (update_ack),
        .period_cnt      (period_cnt),
        .sync_pulse      (sync_pulse),
        .pwm_posedge_reg (pwm_posedge_reg),
        .pwm_negedge_reg (pwm_negedge_reg)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N*W:1] pack_pos();
        logic [N*W:1] v;
        for (int z = 1; z <= N; z++) v[z*W -: W] = m_ac_pos[z];
        return v;
    endfunction

    function automatic logic [N*W:1] pack_neg();
        logic [N*W:1] v;
        for (int z = 1; z <= N; z++) v[z*W -: W] = m_ac_neg[z];
        return v;
    endfunction

    task automatic model_reset();
        m_run_st = 0; m_sync = 0; m_pend = 0; m_ack = 0; m_pcnt = 0; m_per = 0;
        for (int z = 1; z <= N; z++) begin
            m_sh_pos[z] = 0; m_sh_neg[z] = 0; m_ac_pos[z] = 0; m_ac_neg[z] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        logic         boundary, apply, tick_n;
        logic [W-1:0] pcnt_n, per_n;
        if (m_run_st) begin
            tick_n   = (m_pcnt >= prescale_reg);
            pcnt_n   = tick_n ? 8'd0 : 8'(m_pcnt + 1);
            boundary = m_sync && (m_per >= period_reg);
            per_n    = !m_sync ? m_per : (boundary ? 8'd0 : 8'(m_per + 1));
            apply    = m_pend && boundary;
        end else begin
            tick_n = 0; pcnt_n = 0; per_n = 0;
            apply  = m_pend;
        end
        if (apply) begin
            for (int z = 1; z <= N; z++) begin
                m_ac_pos[z] = m_sh_pos[z];
                m_ac_neg[z] = m_sh_neg[z];
            end
        end
        if (cfg_wr_en && cfg_wr_sel >= 1 && cfg_wr_sel <= N) begin
            if (cfg_wr_edge) m_sh_neg[cfg_wr_sel] = cfg_wr_data;
            else             m_sh_pos[cfg_wr_sel] = cfg_wr_data;
        end
        m_pend   = apply ? update_req : (m_pend | update_req);
        m_ack    = apply;
        m_sync   = tick_n;
        m_pcnt   = pcnt_n;
        m_per    = per_n;
        m_run_st = run;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".period_cnt"}, 64'(period_cnt), 64'(m_per));
        check_val({tag, ".sync_pulse"}, 64'(sync_pulse), 64'(m_sync));
        check_val({tag, ".pending"}, 64'(update_pending), 64'(m_pend));
        check_val({tag, ".ack"}, 64'(update_ack), 64'(m_ack));
        check_val({tag, ".pos_reg"}, 64'(pwm_posedge_reg), 64'(pack_pos()));
        check_val({tag, ".neg_reg"}, 64'(pwm_negedge_reg), 64'(pack_neg()));
    endtask

    task automatic cycle(input string tag);
        @(posedge PCLK);
        model_step();
        #1;
        check_all(tag);
        cfg_wr_en  = 0;
        update_req = 0;
    endtask

    task automatic shadow_write(input int sel, input logic edge_sel, input logic [W-1:0] data);
        cfg_wr_en   = 1;
        cfg_wr_sel  = 4'(sel);
        cfg_wr_edge = edge_sel;
        cfg_wr_data = data;
    endtask

    initial begin
        int acks;
        int guard;
        aresetn = 0; run = 0; prescale_reg = 0; period_reg = 0;
        cfg_wr_en = 0; cfg_wr_sel = 0; cfg_wr_edge = 0; cfg_wr_data = 0; update_req = 0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1;
        check_all("reset");
        @(negedge PCLK);
        aresetn = 1;

        // Tick every cycle, period 0..3.
        prescale_reg = 0; period_reg = 3; run = 1;
        repeat (12) cycle("ps0_per3");

        // Tick every third cycle, period 6 cycles.
        prescale_reg = 2; period_reg = 1;
        repeat (20) cycle("ps2_per1");

        // Mid-period write to ch2 posedge, then commit at the wrap.
        prescale_reg = 0; period_reg = 7;
        guard = 0;
        while (m_per != 3 && guard < 40) begin cycle("wait_p3"); guard++; end
        check_val("reach_p3", 64'(guard < 40), 64'd1);
        shadow_write(2, 0, 8'h10);
        cycle("ch2_write");
        update_req = 1;
        cycle("ch2_req");
        check_val("ch2_pending", 64'(update_pending), 64'd1);
        acks = 0; guard = 0;
        while (!m_ack && guard < 20) begin
            check_val("ch2_pos_hold", 64'(pwm_posedge_reg[16:9]), 64'd0);
            cycle("ch2_wait"); guard++;
        end
        check_val("ch2_commit_seen", 64'(guard < 20), 64'd1);
        check_val("ch2_pos_new", 64'(pwm_posedge_reg[16:9]), 64'h10);
        repeat (10) begin cycle("ch2_after"); if (update_ack) acks++; end
        check_val("ch2_no_extra_ack", 64'(acks), 64'd0);

        // Commit while idle lands on the next edge.
        run = 0;
        repeat (3) cycle("idle_enter");
        shadow_write(5, 1, 8'hA5);
        cycle("idle_write");
        update_req = 1;
        cycle("idle_req");
        cycle("idle_apply");
        check_val("idle_ack", 64'(update_ack), 64'd1);
        check_val("idle_neg5", 64'(pwm_negedge_reg[40:33]), 64'hA5);

        // Two requests before one wrap give a single ack.
        run = 1; prescale_reg = 1; period_reg = 5;
        repeat (3) cycle("dbl_start");
        acks = 0;
        update_req = 1; cycle("dbl_req1"); if (update_ack) acks++;
        cycle("dbl_gap"); if (update_ack) acks++;
        update_req = 1; cycle("dbl_req2"); if (update_ack) acks++;
        repeat (30) begin cycle("dbl_wait"); if (update_ack) acks++; end
        check_val("dbl_single_ack", 64'(acks), 64'd1);

        // Lowering the period below the current count wraps on the next tick.
        prescale_reg = 1; period_reg = 10;
        guard = 0;
        while (m_per != 7 && guard < 60) begin cycle("lower_wait"); guard++; end
        check_val("reach_p7", 64'(guard < 60), 64'd1);
        period_reg = 4;
        guard = 0;
        while (m_per == 7 && guard < 6) begin cycle("lower_run"); guard++; end
        check_val("lower_wrap_zero", 64'(period_cnt), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0)
                shadow_write($urandom_range(0, 15), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 15) == 0) update_req = 1;
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 99) == 0) begin
                prescale_reg = 8'($urandom_range(0, 3));
                period_reg   = 8'($urandom_range(0, 7));
            end
            cycle("rand");
        end

        // Asynchronous reset mid-run with a commit pending.
        run = 1; prescale_reg = 2; period_reg = 9;
        repeat (4) cycle("rst_pre");
        shadow_write(1, 0, 8'h3C);
        cycle("rst_write");
        update_req = 1;
        cycle("rst_req");
        #3;
        aresetn = 0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge PCLK);
        aresetn = 1;
        acks = 0;
        repeat (40) begin cycle("rst_after"); if (update_ack) acks++; end
        check_val("rst_no_ack", 64'(acks), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
